// File: rtl/video_tp_pkg.sv
// Shared types, pattern selectors and colour-bar table for the test-pattern generator.
package video_tp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHblank,
    StVblank
  } tp_state_e;

  // Pattern selectors
  localparam logic [1:0] PatXRamp    = 2'd0;
  localparam logic [1:0] PatLineRamp = 2'd1;
  localparam logic [1:0] PatBars     = 2'd2;
  localparam logic [1:0] PatFrameCnt = 2'd3;

  // 100% colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0] BarY [8] = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};
  localparam logic [7:0] BarU [8] = '{8'h80, 8'h10, 8'hA6, 8'h36, 8'hCA, 8'h5A, 8'hF0, 8'h80};
  localparam logic [7:0] BarV [8] = '{8'h80, 8'h92, 8'h10, 8'h22, 8'hDE, 8'hF0, 8'h6E, 8'h80};

  // Byte to emit for the current beat given the selected pattern.
  function automatic logic [7:0] tp_pattern_byte(input logic [1:0]  pat,
                                                 input logic [11:0] x,
                                                 input logic [11:0] line,
                                                 input logic [7:0]  fcnt);
    logic [7:0] res;
    logic [2:0] bar;
    bar = x[10:8];
    res = 8'h00;
    unique case (pat)
      PatXRamp:    res = x[7:0];
      PatLineRamp: res = line[7:0];
      PatBars: begin
        // YUV422 byte order U, Y, V, Y
        unique case (x[1:0])
          2'd0:    res = BarU[bar];
          2'd2:    res = BarV[bar];
          default: res = BarY[bar];
        endcase
      end
      default:     res = fcnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/video_tp_stream_gen.sv
// AXI4-Stream YUV422 video test-pattern generator with line/frame blanking.
module video_tp_stream_gen
  import video_tp_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             enable_i,
  input  logic [11:0]      width_i,
  input  logic [11:0]      height_i,
  input  logic [15:0]      hblank_i,
  input  logic [23:0]      vblank_i,
  input  logic [1:0]       pattern_i,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic [DW/8-1:0]  m_tkeep,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             busy_o
);

  tp_state_e        state_q, state_d;
  logic [11:0]      width_q, width_d;
  logic [11:0]      height_q, height_d;
  logic [15:0]      hblank_q, hblank_d;
  logic [23:0]      vblank_q, vblank_d;
  logic [1:0]       pattern_q, pattern_d;
  logic [11:0]      x_q, x_d;
  logic [11:0]      line_q, line_d;
  logic [23:0]      blank_q, blank_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic cfg_ok;
  logic load_cfg;
  logic handshake;
  logic last_x;
  logic last_line;

  assign cfg_ok    = enable_i && (width_i >= 12'd2) && (height_i >= 12'd1);
  assign handshake = m_tvalid && m_tready;
  assign last_x    = (x_q == (width_q - 12'd1));
  assign last_line = (line_q == (height_q - 12'd1));

  // Next-state: frame/line sequencing, blank counting and config capture at frame start
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    hblank_d    = hblank_q;
    vblank_d    = vblank_q;
    pattern_d   = pattern_q;
    x_d         = x_q;
    line_d      = line_q;
    blank_d     = blank_q;
    frame_cnt_d = frame_cnt_q;
    load_cfg    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_ok) begin
          load_cfg = 1'b1;
          state_d  = StActive;
        end
      end
      StActive: begin
        if (handshake) begin
          if (last_x) begin
            x_d = 12'd0;
            if (last_line) begin
              state_d     = StVblank;
              blank_d     = vblank_q;
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
              line_d = line_q + 12'd1;
              if (hblank_q != 16'd0) begin
                state_d = StHblank;
                blank_d = {8'd0, hblank_q};
              end
            end
          end else begin
            x_d = x_q + 12'd1;
          end
        end
      end
      StHblank: begin
        if (blank_q <= 24'd1) begin
          state_d = StActive;
        end else begin
          blank_d = blank_q - 24'd1;
        end
      end
      StVblank: begin
        // A zero vblank still spends one cycle here
        if (blank_q <= 24'd1) begin
          if (cfg_ok) begin
            load_cfg = 1'b1;
            state_d  = StActive;
          end else begin
            state_d = StIdle;
          end
        end else begin
          blank_d = blank_q - 24'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_cfg) begin
      width_d   = {width_i[11:1], 1'b0};
      height_d  = height_i;
      hblank_d  = hblank_i;
      vblank_d  = vblank_i;
      pattern_d = pattern_i;
      x_d       = 12'd0;
      line_d    = 12'd0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      width_q     <= 12'd0;
      height_q    <= 12'd0;
      hblank_q    <= 16'd0;
      vblank_q    <= 24'd0;
      pattern_q   <= 2'd0;
      x_q         <= 12'd0;
      line_q      <= 12'd0;
      blank_q     <= 24'd0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      pattern_q   <= pattern_d;
      x_q         <= x_d;
      line_q      <= line_d;
      blank_q     <= blank_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Stream outputs decode from registered state; x only moves on handshake, so stalls hold them
  always_comb begin
    m_tvalid    = (state_q == StActive);
    m_tuser     = m_tvalid && (x_q == 12'd0) && (line_q == 12'd0);
    m_tlast     = m_tvalid && last_x;
    m_tkeep     = '1;
    m_tdata     = '0;
    if (m_tvalid) begin
      m_tdata = DW'(tp_pattern_byte(pattern_q, x_q, line_q, 8'(frame_cnt_q)));
    end
    busy_o      = (state_q != StIdle);
    frame_cnt_o = frame_cnt_q;
  end

endmodule

// File: tb/tb_video_tp_stream_gen.sv
// Self-checking bench: config table run against a frame-level reference model, plus corner cases.
module tb_video_tp_stream_gen;

  logic        ACLK;
  logic        ARESET;
  logic        enable_i;
  logic [11:0] width_i;
  logic [11:0] height_i;
  logic [15:0] hblank_i;
  logic [23:0] vblank_i;
  logic [1:0]  pattern_i;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic [0:0]  m_tkeep;
  logic [15:0] frame_cnt_o;
  logic        busy_o;

  video_tp_stream_gen #(.DW(8), .CNT_W(16)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .enable_i    (enable_i),
    .width_i     (width_i),
    .height_i    (height_i),
    .hblank_i    (hblank_i),
    .vblank_i    (vblank_i),
    .pattern_i   (pattern_i),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .m_tkeep     (m_tkeep),
    .frame_cnt_o (frame_cnt_o),
    .busy_o      (busy_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int w;
    int h;
    int hb;
    int vb;
    int pat;
    int rnd;
    int frames;
  } cfg_t;

  cfg_t vec [8];

  // Independent copy of the 100% colour-bar values (white..black)
  logic [7:0] bar_y [8] = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};
  logic [7:0] bar_u [8] = '{8'h80, 8'h10, 8'hA6, 8'h36, 8'hCA, 8'h5A, 8'hF0, 8'h80};
  logic [7:0] bar_v [8] = '{8'h80, 8'h92, 8'h10, 8'h22, 8'hDE, 8'hF0, 8'h6E, 8'h80};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int pat, input int x, input int ln, input int fc);
    int bar;
    int ph;
    bar = (x / 256) % 8;
    ph  = x % 4;
    case (pat)
      0: return 8'(x % 256);
      1: return 8'(ln % 256);
      2: begin
        if (ph == 0) return bar_u[bar];
        else if (ph == 2) return bar_v[bar];
        else return bar_y[bar];
      end
      default: return 8'(fc % 256);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge ACLK);
    ARESET   = 1'b1;
    enable_i = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("reset_state", 32'({m_tvalid, m_tuser, m_tlast, m_tdata, busy_o, frame_cnt_o}), 32'd0);
    chk("reset_keep", 32'(m_tkeep), 32'd1);
    ARESET = 1'b0;
  endtask

  task automatic apply_cfg(input cfg_t c);
    width_i   = 12'(c.w);
    height_i  = 12'(c.h);
    hblank_i  = 16'(c.hb);
    vblank_i  = 24'(c.vb);
    pattern_i = 2'(c.pat);
  endtask

  // Runs c.frames frames, dropping enable once drop_after beats have been transferred.
  task automatic run_stream(input cfg_t c, input int drop_after, input string tag);
    int we, fb, total_beats, beats, gap, exp_gap, budget;
    int f, r, ln, x;
    bit have_gap, stall_prev, done;
    logic [7:0]  pd;
    logic        pu, pl;
    logic [10:0] exp_beat;
    we          = c.w & ~1;
    fb          = we * c.h;
    total_beats = c.frames * fb;
    budget      = total_beats * 4 + c.frames * (c.h * (c.hb + 2) + c.vb + 4) + 200;
    beats = 0; gap = 0; exp_gap = 0;
    have_gap = 0; stall_prev = 0; done = 0;
    pd = 8'h00; pu = 1'b0; pl = 1'b0;

    do_reset();
    apply_cfg(c);
    enable_i = 1'b1;
    @(negedge ACLK);
    chk({tag, "_first_valid"}, 32'(m_tvalid), 32'd1);

    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      if (cyc != 0) @(negedge ACLK);
      if (beats >= drop_after) enable_i = 1'b0;
      m_tready = (c.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_prev) begin
        chk({tag, "_stall_hold"}, 32'({m_tvalid, m_tdata, m_tuser, m_tlast}),
            32'({1'b1, pd, pu, pl}));
      end
      if (m_tvalid) begin
        if (have_gap) chk({tag, "_gap"}, 32'(gap), 32'(exp_gap));
        have_gap = 0;
        if (m_tready) begin
          f  = beats / fb;
          r  = beats % fb;
          ln = r / we;
          x  = r % we;
          exp_beat = {exp_byte(c.pat, x, ln, f), 1'(x == 0 && ln == 0), 1'(x == we - 1), 1'b1};
          chk({tag, "_beat"}, 32'({m_tdata, m_tuser, m_tlast, m_tkeep}), 32'(exp_beat));
          chk({tag, "_fcnt_mid"}, 32'(frame_cnt_o), 32'(f));
          beats++;
          if (x == we - 1) begin
            have_gap = 1;
            gap      = 0;
            exp_gap  = (r == fb - 1) ? ((c.vb > 0) ? c.vb : 1) : c.hb;
          end
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          pd = m_tdata; pu = m_tuser; pl = m_tlast;
        end
      end else begin
        gap++;
        stall_prev = 0;
        if (beats >= total_beats && !busy_o) done = 1;
      end
    end

    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: beats=%0d expected %0d busy=%0d", tag, beats, total_beats,
               busy_o);
    end
    chk({tag, "_beats"}, 32'(beats), 32'(total_beats));
    chk({tag, "_fcnt_end"}, 32'(frame_cnt_o), 32'(c.frames));
    chk({tag, "_idle"}, 32'({busy_o, m_tvalid}), 32'd0);
  endtask

  task automatic reset_midline();
    cfg_t c;
    int   beats;
    bit   hit;
    c = '{w: 8, h: 2, hb: 3, vb: 5, pat: 0, rnd: 0, frames: 1};
    beats = 0;
    hit   = 0;
    do_reset();
    apply_cfg(c);
    enable_i = 1'b1;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge ACLK);
      if (m_tvalid && beats == 4) hit = 1;
      else if (m_tvalid) beats++;
    end
    chk("rst_reached_x4", 32'({hit, m_tdata}), 32'({1'b1, 8'h04}));
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("rst_mid_drop", 32'({m_tvalid, m_tlast, busy_o, frame_cnt_o}), 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_restart_sof", 32'({m_tvalid, m_tuser, m_tdata}), 32'({1'b1, 1'b1, 8'h00}));
    enable_i = 1'b0;
  endtask

  task automatic bad_cfg(input int w, input int h, input string tag);
    logic seen;
    seen = 1'b0;
    do_reset();
    width_i  = 12'(w);
    height_i = 12'(h);
    enable_i = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge ACLK);
      seen = seen | m_tvalid | busy_o;
    end
    chk(tag, 32'(seen), 32'd0);
    enable_i = 1'b0;
  endtask

  initial begin
    ARESET    = 1'b1;
    enable_i  = 1'b0;
    width_i   = 12'd0;
    height_i  = 12'd0;
    hblank_i  = 16'd0;
    vblank_i  = 24'd0;
    pattern_i = 2'd0;
    m_tready  = 1'b1;

    vec[0] = '{w: 8,    h: 2, hb: 3, vb: 5, pat: 0, rnd: 0, frames: 1};
    vec[1] = '{w: 8,    h: 2, hb: 3, vb: 5, pat: 0, rnd: 1, frames: 2};
    vec[2] = '{w: 8,    h: 3, hb: 0, vb: 5, pat: 0, rnd: 0, frames: 1};
    vec[3] = '{w: 6,    h: 4, hb: 2, vb: 0, pat: 1, rnd: 1, frames: 2};
    vec[4] = '{w: 4,    h: 2, hb: 1, vb: 0, pat: 3, rnd: 0, frames: 3};
    vec[5] = '{w: 7,    h: 2, hb: 1, vb: 2, pat: 0, rnd: 1, frames: 1};
    vec[6] = '{w: 1280, h: 1, hb: 0, vb: 0, pat: 2, rnd: 0, frames: 1};
    vec[7] = '{w: 12,   h: 3, hb: 0, vb: 0, pat: 2, rnd: 1, frames: 2};

    for (int i = 0; i < 8; i++) begin
      run_stream(vec[i], (vec[i].frames - 1) * (vec[i].w & ~1) * vec[i].h + 1,
                 $sformatf("vec%0d", i));
    end

    // Enable dropped after two beats: frame still completes, then idle
    run_stream('{w: 8, h: 2, hb: 3, vb: 5, pat: 0, rnd: 0, frames: 1}, 2, "en_drop");

    reset_midline();
    bad_cfg(1, 4, "bad_width");
    bad_cfg(8, 0, "bad_height");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_tp_stream_gen.md
VIDEO_TP_STREAM_GEN -- requirements
Module: video_tp_stream_gen

Interface
REQ-001 SHALL have parameter DW, default 8: AXI4-Stream data width in bits; only 8 is supported.
REQ-002 SHALL have parameter CNT_W, default 16: width of frame_cnt_o.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock.
REQ-004 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable_i, input, 1 bit: run request.
REQ-006 SHALL have port width_i, input, 12 bits: bytes per line (2 bytes per pixel, YUV422).
REQ-007 SHALL have port height_i, input, 12 bits: lines per frame.
REQ-008 SHALL have port hblank_i, input, 16 bits: idle cycles after each line.
REQ-009 SHALL have port vblank_i, input, 24 bits: idle cycles after each frame.
REQ-010 SHALL have port pattern_i, input, 2 bits: pattern select.
REQ-011 SHALL have port m_tdata, output, DW bits: stream data.
REQ-012 SHALL have port m_tvalid, output, 1 bit: stream valid.
REQ-013 SHALL have port m_tready, input, 1 bit: downstream ready.
REQ-014 SHALL have port m_tuser, output, 1 bit: start of frame.
REQ-015 SHALL have port m_tlast, output, 1 bit: end of line.
REQ-016 SHALL have port m_tkeep, output, DW/8 bits: byte enables.
REQ-017 SHALL have port frame_cnt_o, output, CNT_W bits: completed frames.
REQ-018 SHALL have port busy_o, output, 1 bit: state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, ACTIVE, HBLANK and VBLANK.
REQ-020 IDLE->ACTIVE SHALL occur when enable_i=1, width_i>=2 and height_i>=1; otherwise the block stays in IDLE.
REQ-021 SHALL latch width_i (LSB forced to 0), height_i, hblank_i, vblank_i and pattern_i on IDLE->ACTIVE and on VBLANK->ACTIVE; mid-frame input changes SHALL be ignored.
REQ-022 m_tvalid SHALL be 1 on the first cycle in ACTIVE, i.e. one cycle after enable_i is sampled high in IDLE.
REQ-023 In ACTIVE, x (byte index) SHALL advance only on handshake (m_tvalid and m_tready both 1).
REQ-024 While m_tvalid=1 and m_tready=0, m_tdata, m_tuser and m_tlast SHALL hold stable.
REQ-025 m_tuser SHALL be 1 only on beat x=0 of line 0.
REQ-026 m_tlast SHALL be 1 on beat x=width-1 of every line.
REQ-027 m_tkeep SHALL be all ones.
REQ-028 On the tlast handshake: if lines remain and hblank>0, go to HBLANK; if lines remain and hblank=0, go to ACTIVE with the next line back-to-back (no bubble); on the last line, go to VBLANK.
REQ-029 HBLANK SHALL last exactly hblank cycles with m_tvalid=0, counted regardless of m_tready, then return to ACTIVE.
REQ-030 VBLANK SHALL last exactly vblank cycles with m_tvalid=0; vblank=0 SHALL take one cycle.
REQ-031 At VBLANK end, the block SHALL start a new frame if enable_i=1, else go to IDLE.
REQ-032 Deasserting enable_i mid-frame SHALL let the current frame complete; frames are never truncated.
REQ-033 frame_cnt_o SHALL increment on the handshake of the last tlast of a frame and wrap from all ones to 0.
REQ-034 Pattern 0 SHALL output x[7:0].
REQ-035 Pattern 1 SHALL output line[7:0].
REQ-036 Pattern 2 SHALL output 8 colour bars, bar index x[10:8], byte order U,Y,V,Y by x[1:0], values taken from the package table.
REQ-037 Pattern 3 SHALL output frame_cnt_o[7:0], constant for the whole frame.
REQ-038 Counters SHALL be sized for the maximum values: x and line 12 bits, blank counter 24 bits; no overflow is possible.

Reset
REQ-039 On ARESET=1 at a clock edge, the block SHALL enter IDLE and set m_tvalid, m_tuser, m_tlast, m_tdata, busy_o and frame_cnt_o to 0; m_tkeep SHALL be all ones.
REQ-040 Reset mid-line SHALL drop m_tvalid on the next edge with no tlast emitted; downstream resynchronises on the next tuser.
REQ-041 ARESET SHALL take priority over all other events.

Structure
REQ-042 Package video_tp_pkg SHALL hold the state enum, the pattern-select constants and the 8-entry Y/U/V colour-bar table.
REQ-043 SHALL be a single module with no sub-modules; the pattern mux SHALL be a function in the package.

Verification
REQ-044 width=8, height=2, hblank=3, vblank=5, pattern 0, tready=1 -> beats 00..07 per line; tuser on beat 0 of line 0; tlast on beats 7 and 15; 3 idle cycles between lines; frame_cnt=1 at the end of the frame.
REQ-045 Same configuration, tready toggled pseudo-randomly -> the bench checks data, tuser and tlast stability during stalls and that exactly 16 beats are transferred per frame.
REQ-046 hblank=0, height=3 -> lines are back-to-back with no m_tvalid gap; tlast on beats 7, 15 and 23.
REQ-047 enable_i dropped after 2 beats -> the full frame completes, then the block goes to IDLE (busy_o=0) and frame_cnt=1.
REQ-048 ARESET pulsed at x=4 -> m_tvalid=0 on the next cycle and frame_cnt=0; after release with enable_i=1, the first beat carries tuser.
REQ-049 width_i=1 or height_i=0 with enable_i=1 -> the block stays in IDLE with m_tvalid=0; width_i=1280, pattern 2 -> the bar index changes every 256 bytes.
